// File: rtl/fan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fan_pkg
// Description : Shared state encoding and default constants for the fan
//               angle tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
package fan_pkg;

  // Revolution tracking states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } fan_state_e;

  localparam int TICKS_PER_REV_DEF = 360;
  localparam int MIN_PERIOD_DEF    = 1000;
  localparam int CNT_W_DEF         = 24;
  localparam int SYNC_STAGES_DEF   = 2;

endpackage
`default_nettype wire

// File: rtl/hall_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : hall_sync_edge
// Description : Multi-flop synchronizer for the raw Hall index input followed
//               by a rising-edge detector. The rise output is combinational
//               from the last two flops so the parent can register it.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_sync_edge
  import fan_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic hall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the raw input through the synchronizer chain
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = hall;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/fan_angle_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : fan_angle_tick_gen
// Description : Measures the Hall revolution period and spreads TICKS_PER_REV
//               evenly spaced one-cycle fanclk ticks over the next revolution.
//               Optional macro FAN_PERIOD_AVG_EN: while locked, each new
//               period is averaged (rounded) with the previous one.
// Revision    : 1.0 - initial release
// ============================================================================
module fan_angle_tick_gen
  import fan_pkg::*;
#(
  parameter int TICKS_PER_REV = TICKS_PER_REV_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int MIN_PERIOD    = MIN_PERIOD_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall,
  output logic             fanclk,
  output logic             index,
  output logic             locked,
  output logic [CNT_W-1:0] rev_period
);

  localparam int                ACC_W    = CNT_W + 9;
  localparam int                TCNT_W   = $clog2(TICKS_PER_REV + 1);
  localparam logic [CNT_W:0]    MIN_P    = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [ACC_W-1:0]  ACC_STEP = ACC_W'(TICKS_PER_REV);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TICKS_PER_REV);

  fan_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rev_period_q, rev_period_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              fanclk_q, fanclk_d;
  logic              index_q, index_d;

  logic              hall_rise;
  logic [CNT_W:0]    cnt_inc;
  logic              cnt_sat;
  logic              accept;
  logic [CNT_W-1:0]  meas;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  rp_ext;

  hall_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .hall (hall),
    .rise (hall_rise)
  );

  // cnt+1 is carried one bit wider so a saturated counter never wraps to a short period
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_sat = &cnt_q;
  assign meas    = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
  assign accept  = hall_rise && ((state_q == IDLE) || (cnt_inc >= MIN_P));
  assign acc_sum = acc_q + ACC_STEP;
  assign rp_ext  = ACC_W'(rev_period_q);

`ifdef FAN_PERIOD_AVG_EN
  logic [CNT_W+1:0] avg_sum;
  logic [CNT_W:0]   avg_half;
  logic [CNT_W-1:0] avg_val;
  assign avg_sum  = {2'b00, rev_period_q} + {2'b00, cnt_q} + (CNT_W+2)'(2);
  assign avg_half = avg_sum[CNT_W+1:1];
  assign avg_val  = avg_half[CNT_W] ? {CNT_W{1'b1}} : avg_half[CNT_W-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accepted edges advance, counter saturation drops to IDLE
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: state_d = LOCKED;
        LOCKED:  state_d = LOCKED;
        default: state_d = IDLE;
      endcase
    end else if (cnt_sat) begin
      state_d = IDLE;
    end
  end

  // Outputs are all taken straight from flops
  always_comb begin
    fanclk     = fanclk_q;
    index      = index_q;
    locked     = (state_q == LOCKED);
    rev_period = rev_period_q;
  end

  // Period counter, period capture and phase-accumulator tick generation
  always_comb begin
    cnt_d        = cnt_q;
    rev_period_d = rev_period_q;
    acc_d        = acc_q;
    tcnt_d       = tcnt_q;
    fanclk_d     = 1'b0;
    index_d      = accept;

    if (accept) begin
      cnt_d = '0;
    end else if (!cnt_sat) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end

    if (accept && (state_q == ACQUIRE)) begin
      rev_period_d = meas;
    end else if (accept && (state_q == LOCKED)) begin
`ifdef FAN_PERIOD_AVG_EN
      rev_period_d = avg_val;
`else
      rev_period_d = meas;
`endif
    end

    // An accepted edge restarts the revolution and suppresses any tick due now
    if (accept || (state_q != LOCKED)) begin
      acc_d  = '0;
      tcnt_d = '0;
    end else if (acc_sum >= rp_ext) begin
      if (tcnt_q < TCNT_MAX) begin
        fanclk_d = 1'b1;
        acc_d    = acc_sum - rp_ext;
        tcnt_d   = tcnt_q + TCNT_W'(1);
      end
    end else begin
      acc_d = acc_sum;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      rev_period_q <= '0;
      acc_q        <= '0;
      tcnt_q       <= '0;
      fanclk_q     <= 1'b0;
      index_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rev_period_q <= rev_period_d;
      acc_q        <= acc_d;
      tcnt_q       <= tcnt_d;
      fanclk_q     <= fanclk_d;
      index_q      <= index_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fan_angle_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fan_angle_tick_gen
// Description : Self-checking bench for fan_angle_tick_gen. Expected index
//               and tick times are queued when each Hall edge is driven and
//               matched against the DUT outputs on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fan_angle_tick_gen;

  localparam int T    = 36;
  localparam int CW   = 14;
  localparam int MINP = 1000;
  localparam int SS   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          hall;
  logic          fanclk;
  logic          index;
  logic          locked;
  logic [CW-1:0] rev_period;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;
  int tick_q[$];
  int idx_q[$];
  int st     = 0;   // 0 idle, 1 acquire, 2 locked
  int exp_rp = 0;
  int prev_n = 0;

  fan_angle_tick_gen #(
    .TICKS_PER_REV (T),
    .CNT_W         (CW),
    .MIN_PERIOD    (MINP),
    .SYNC_STAGES   (SS)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .hall       (hall),
    .fanclk     (fanclk),
    .index      (index),
    .locked     (locked),
    .rev_period (rev_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Match fanclk/index pulses against the scheduled times
  always @(negedge clk) begin : mon
    bit et;
    bit ei;
    if (mon_en) begin
      et = 1'b0;
      ei = 1'b0;
      if (tick_q.size() != 0) begin
        if (tick_q[0] == cyc) begin
          et = 1'b1;
          void'(tick_q.pop_front());
        end
      end
      if (idx_q.size() != 0) begin
        if (idx_q[0] == cyc) begin
          ei = 1'b1;
          void'(idx_q.pop_front());
        end
      end
      if ((fanclk !== 1'b0) || et) chk("fanclk", {31'd0, fanclk}, {31'd0, et});
      if ((index !== 1'b0) || ei) chk("index", {31'd0, index}, {31'd0, ei});
    end
  end

  // Drive one accepted Hall rise; L is the gap to the next rise (0 = none follows)
  task automatic rev(input int L, input bit glitch);
    int n;
    int d;
    int k;
    hall = 1'b1;
    n    = cyc;
    d    = n + SS + 1;
    case (st)
      0: st = 1;
      1: begin
        exp_rp = n - prev_n;
        st     = 2;
      end
      default: begin
`ifdef FAN_PERIOD_AVG_EN
        exp_rp = (exp_rp + (n - prev_n) + 1) / 2;
`else
        exp_rp = n - prev_n;
`endif
      end
    endcase
    prev_n = n;
    idx_q.push_back(d);
    if (st == 2) begin
      // Tick m lands on the first cycle where m*rev_period fits in k*T;
      // a tick falling on the next edge is absorbed by that edge
      for (int m = 1; m <= T; m++) begin
        k = (m * exp_rp + T - 1) / T;
        if ((L <= 0) || (k < L)) tick_q.push_back(d + k);
      end
    end
    step_to(d);
    @(negedge clk);
    chk("locked_after_edge", {31'd0, locked}, (st == 2) ? 32'd1 : 32'd0);
    chk("rev_period_after_edge", 32'(rev_period), exp_rp);
    step_to(n + 20);
    hall = 1'b0;
    if (glitch) begin
      step_to(n + 200);
      hall = 1'b1;
      step_to(n + 220);
      hall = 1'b0;
      step_to(n + 400);
      chk("rev_period_after_glitch", 32'(rev_period), exp_rp);
    end
    if (L > 0) step_to(n + L);
  endtask

  initial begin
    int d;
    rst  = 1'b0;
    hall = 1'b0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 hall = ~hall;
    end
    @(negedge clk);
    chk("reset_fanclk", {31'd0, fanclk}, 32'd0);
    chk("reset_index", {31'd0, index}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_rev_period", 32'(rev_period), 32'd0);
    hall = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    step_to(cyc + 5);

    // Acquire and lock on a steady period, then a glitch, then slowdown
    rev(3600, 1'b0);
    rev(3600, 1'b0);
    rev(3600, 1'b1);
    rev(7200, 1'b0);
    rev(7200, 1'b0);

    // Hall stops: counter saturates and the block unlocks
    rev(0, 1'b0);
    d = prev_n + SS + 1;
    step_to(d + 16300);
    @(negedge clk);
    chk("locked_before_timeout", {31'd0, locked}, 32'd1);
    step_to(d + 16400);
    @(negedge clk);
    chk("locked_after_timeout", {31'd0, locked}, 32'd0);
    chk("rev_period_hold_timeout", 32'(rev_period), exp_rp);
    st = 0;
    step_to(cyc + 10);

    // Relock (raw load on ACQUIRE->LOCKED), then a changed period
    rev(3600, 1'b0);
    rev(3600, 1'b0);
    rev(3620, 1'b0);
    rev(0, 1'b0);
    step_to(prev_n + 4000);
    @(negedge clk);
    chk("ticks_outstanding", tick_q.size(), 32'd0);
    chk("index_outstanding", idx_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
